// File: rtl/uart_cmd_parser.sv
// UART command parser: "L"/"D" + two hex digits + CR/LF writes led_value/div_value and answers 'K' or '?'.
// Define UART_CMD_PARSER_ECHO_EN to echo every received byte; the response FIFO then grows from 2 to 4 entries.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0]  DIV_RESET      = 8'd25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  input  logic       tx_busy,
  output logic [7:0] led_value,
  output logic [7:0] div_value,
  output logic       div_update,
  output logic       cmd_error
);

  typedef enum logic [2:0] {S_IDLE, S_HEX_HI, S_HEX_LO, S_TERM, S_FLUSH} state_t;

  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_D   = 8'h44;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_ACK = 8'h4B;
  localparam logic [7:0] CH_NAK = 8'h3F;

`ifdef UART_CMD_PARSER_ECHO_EN
  localparam int unsigned FIFO_DEPTH = 4;
`else
  localparam int unsigned FIFO_DEPTH = 2;
`endif
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  // Letters A-F/a-f share low nibble 1..6, so adding 9 yields 10..15.
  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
  endfunction

  state_t           state, state_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting, timeout_hit;
  logic             rx_term, rx_hex, rx_opcode;
  logic             opcode_div;
  logic [3:0]       nib_hi, nib_lo;
  logic             resp_push, parse_err, commit;
  logic [7:0]       resp_byte;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   free_slots;
  logic             echo_push, pop, echo_ok, resp_ok, push_drop;
  logic [1:0]       n_push;

  assign rx_term     = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign rx_hex      = is_hex(rx_data);
  assign rx_opcode   = (rx_data == CH_L) || (rx_data == CH_D);
  assign waiting     = (state == S_HEX_HI) || (state == S_HEX_LO) || (state == S_TERM);
  assign timeout_hit = waiting && !new_rx_data && (tmo_cnt == TMO_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: defaulting every output first keeps always_comb free of inferred latches.
  always_comb begin
    state_next = state;
    if (new_rx_data) begin
      case (state)
        S_IDLE:   if (rx_opcode) state_next = S_HEX_HI;
                  else if (!rx_term) state_next = S_FLUSH;
        S_HEX_HI: if (rx_hex) state_next = S_HEX_LO;
                  else state_next = rx_term ? S_IDLE : S_FLUSH;
        S_HEX_LO: if (rx_hex) state_next = S_TERM;
                  else state_next = rx_term ? S_IDLE : S_FLUSH;
        S_TERM:   state_next = rx_term ? S_IDLE : S_FLUSH;
        S_FLUSH:  if (rx_term) state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    resp_push = 1'b0;
    resp_byte = CH_NAK;
    parse_err = 1'b0;
    commit    = 1'b0;
    if (new_rx_data) begin
      case (state)
        S_IDLE: if (!rx_opcode && !rx_term) begin
          resp_push = 1'b1;
          parse_err = 1'b1;
        end
        S_HEX_HI, S_HEX_LO: if (!rx_hex) begin
          resp_push = 1'b1;
          parse_err = 1'b1;
        end
        S_TERM: begin
          resp_push = 1'b1;
          if (rx_term) begin
            commit    = 1'b1;
            resp_byte = CH_ACK;
          end else begin
            parse_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_div <= 1'b0;
      nib_hi     <= 4'd0;
      nib_lo     <= 4'd0;
    end else if (new_rx_data) begin
      case (state)
        S_IDLE:   if (rx_opcode) opcode_div <= (rx_data == CH_D);
        S_HEX_HI: if (rx_hex) nib_hi <= hex_nibble(rx_data);
        S_HEX_LO: if (rx_hex) nib_lo <= hex_nibble(rx_data);
        default:  ;
      endcase
    end
  end

  // Idle-cycle counter only runs while a command is partially received.
  always_ff @(posedge clk) begin
    if (rst || new_rx_data || !waiting) tmo_cnt <= '0;
    else                                tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_value  <= 8'd0;
      div_value  <= DIV_RESET;
      div_update <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      div_update <= commit && opcode_div;
      cmd_error  <= parse_err || timeout_hit || push_drop;
      if (commit) begin
        if (opcode_div) div_value <= {nib_hi, nib_lo};
        else            led_value <= {nib_hi, nib_lo};
      end
    end
  end

`ifdef UART_CMD_PARSER_ECHO_EN
  assign echo_push = new_rx_data;
`else
  assign echo_push = 1'b0;
`endif

  // Echo goes in ahead of the response; a pop in the same cycle frees one slot.
  assign pop        = (fifo_cnt != '0) && !tx_busy && !new_tx_data;
  assign free_slots = DEPTH_EXT - {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, pop};
  assign echo_ok    = echo_push && (free_slots != '0);
  assign resp_ok    = resp_push && (free_slots > {{CNT_W{1'b0}}, echo_ok});
  assign push_drop  = (echo_push && !echo_ok) || (resp_push && !resp_ok);
  assign n_push     = {1'b0, echo_ok} + {1'b0, resp_ok};

  // NOTE: FIFO storage is not reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (echo_ok) fifo_mem[wr_ptr] <= rx_data;
    if (resp_ok) fifo_mem[echo_ok ? wr_ptr + PTR_W'(1) : wr_ptr] <= resp_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      tx_data     <= 8'd0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= pop;
      if (pop) begin
        tx_data <= fifo_mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      wr_ptr   <= wr_ptr + PTR_W'(n_push);
      fifo_cnt <= fifo_cnt + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized
// command streams compared with a prefix-based command model.
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 100;
  localparam logic [7:0] DIV_RST = 8'd25;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic [7:0] led_value, div_value;
  logic       div_update, cmd_error;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO), .DIV_RESET(DIV_RST)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .led_value(led_value), .div_value(div_value), .div_update(div_update),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [7:0] tx_log[$];
  int         tx_cyc_log[$];
  int         err_seen = 0, upd_seen = 0, err_cyc = -1, last_tx_cyc = -100;
  always @(negedge clk) begin
    if (new_tx_data) begin
      check("tx_gap", ((cyc - last_tx_cyc) >= 2) ? 1 : 0, 1);
      last_tx_cyc = cyc;
      tx_log.push_back(tx_data);
      tx_cyc_log.push_back(cyc);
    end
    if (cmd_error) begin
      err_seen++;
      err_cyc = cyc;
    end
    if (div_update) upd_seen++;
  end

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hDEAD;
  endfunction
  function automatic int cyc_at(input int i);
    return (i < tx_cyc_log.size()) ? tx_cyc_log[i] : -1000;
  endfunction

  // Reference model: holds the bytes of the command received so far.
  logic [7:0] m_buf[$];
  logic [7:0] m_exp_tx[$];
  bit         m_flush;
  logic [7:0] m_led, m_div;
  int         m_err, m_upd;

  function automatic bit m_is_hex(input logic [7:0] b);
    return (b inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]});
  endfunction
  function automatic int m_hex_val(input logic [7:0] b);
    if (b <= 8'h39) return int'(b) - 48;
    if (b <= 8'h46) return int'(b) - 55;
    return int'(b) - 87;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_exp_tx.delete();
    m_flush = 0;
    m_led = 8'd0;
    m_div = DIV_RST;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit term, ok;
    int v;
    term = (b == 8'h0D) || (b == 8'h0A);
    if (m_flush) begin
      if (term) m_flush = 0;
    end else if (term) begin
      if (m_buf.size() == 3) begin
        v = m_hex_val(m_buf[1]) * 16 + m_hex_val(m_buf[2]);
        if (m_buf[0] == 8'h4C) m_led = 8'(v);
        else begin
          m_div = 8'(v);
          m_upd++;
        end
        m_exp_tx.push_back(8'h4B);
      end else if (m_buf.size() != 0) begin
        m_exp_tx.push_back(8'h3F);
        m_err++;
      end
      m_buf.delete();
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 1) ok = (b == 8'h4C) || (b == 8'h44);
      else                   ok = (m_buf.size() <= 3) && m_is_hex(b);
      if (!ok) begin
        m_exp_tx.push_back(8'h3F);
        m_err++;
        m_buf.delete();
        m_flush = 1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int strobe_cyc;
  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    strobe_cyc  = cyc - 1;
    new_rx_data = 1'b0;
    rx_data     = 8'($urandom);
    model_byte(b);
  endtask

  logic [7:0] seq[$];
  task automatic send_seq(input int gap);
    foreach (seq[i]) begin
      if (i > 0) tick(gap);
      send_byte(seq[i]);
    end
    seq.delete();
  endtask

  function automatic logic [7:0] hex_char(input int n, input bit upper);
    if (n < 10) return 8'(48 + n);
    return upper ? 8'(55 + n) : 8'(87 + n);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int mark, err_base, upd_base, t0, n_exp;
  logic [7:0] b;

  initial begin
    rst = 1'b1; rx_data = 8'd0; new_rx_data = 1'b0; tx_busy = 1'b0;
    model_reset();
    tick(3);
    @(negedge clk);
    check("rst_tx_data", tx_data, 0);
    check("rst_new_tx", new_tx_data, 0);
    check("rst_led", led_value, 0);
    check("rst_div", div_value, DIV_RST);
    check("rst_div_update", div_update, 0);
    check("rst_cmd_error", cmd_error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_new_tx", new_tx_data, 0);
    @(posedge clk); #1;
    tick(2);

    // LED write and response latency
    mark = tx_log.size();
    seq = '{8'h4C, 8'h41, 8'h35, 8'h0A};
    send_seq(2);
    check("led_a5", led_value, 8'hA5);
    tick(6);
    check("led_tx_cnt", tx_log.size() - mark, 1);
    check("led_tx_k", tx_at(mark), 8'h4B);
    check("led_latency", cyc_at(mark) - strobe_cyc, 2);

    // DIV write, lower-case hex
    mark = tx_log.size(); upd_base = upd_seen;
    seq = '{8'h44, 8'h30, 8'h63, 8'h0D};
    send_seq(3);
    check("div_0c", div_value, 8'h0C);
    tick(6);
    check("div_update_cnt", upd_seen - upd_base, 1);
    check("div_tx_k", tx_at(mark), 8'h4B);

    // Bad opcode then recovery
    mark = tx_log.size(); err_base = err_seen;
    seq = '{8'h58, 8'h31, 8'h0A};
    send_seq(2);
    tick(6);
    check("bad_tx_cnt", tx_log.size() - mark, 1);
    check("bad_tx_nak", tx_at(mark), 8'h3F);
    check("bad_err_cnt", err_seen - err_base, 1);
    check("bad_led_kept", led_value, 8'hA5);
    check("bad_div_kept", div_value, 8'h0C);
    seq = '{8'h4C, 8'h30, 8'h31, 8'h0A};
    send_seq(2);
    check("led_01", led_value, 8'h01);
    tick(6);
    check("led01_tx_k", tx_at(mark + 1), 8'h4B);

    // Timeout mid-command
    mark = tx_log.size(); err_base = err_seen;
    seq = '{8'h4C, 8'h33};
    send_seq(2);
    t0 = strobe_cyc;
    tick(TMO + 6);
    m_buf.delete();
    check("tmo_err_cnt", err_seen - err_base, 1);
    check("tmo_err_time", ((err_cyc - t0) >= TMO && (err_cyc - t0) <= TMO + 1) ? 1 : 0, 1);
    check("tmo_no_tx", tx_log.size() - mark, 0);
    check("tmo_led_kept", led_value, 8'h01);
    seq = '{8'h4C, 8'h37, 8'h37, 8'h0A};
    send_seq(2);
    check("tmo_then_led77", led_value, 8'h77);
    tick(6);

    // FIFO overflow with transmitter busy
    tx_busy = 1'b1;
    mark = tx_log.size(); err_base = err_seen; upd_base = upd_seen;
    seq = '{8'h4C, 8'h31, 8'h31, 8'h0A}; send_seq(2); tick(3);
    seq = '{8'h44, 8'h32, 8'h32, 8'h0D}; send_seq(2); tick(3);
    seq = '{8'h4C, 8'h33, 8'h33, 8'h0A}; send_seq(2); tick(4);
    check("ovf_err_cnt", err_seen - err_base, 1);
    check("ovf_none_busy", tx_log.size() - mark, 0);
    check("ovf_led", led_value, 8'h33);
    check("ovf_div", div_value, 8'h22);
    tx_busy = 1'b0;
    tick(10);
    check("ovf_tx_cnt", tx_log.size() - mark, 2);
    check("ovf_tx0", tx_at(mark), 8'h4B);
    check("ovf_tx1", tx_at(mark + 1), 8'h4B);
    check("ovf_spacing", ((cyc_at(mark + 1) - cyc_at(mark)) >= 2) ? 1 : 0, 1);

    // Reset mid-command with a response still queued
    tx_busy = 1'b1;
    mark = tx_log.size();
    seq = '{8'h5A, 8'h0A, 8'h44, 8'h46};
    send_seq(2);
    tick(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_busy = 1'b0;
    model_reset();
    check("mid_rst_div", div_value, DIV_RST);
    check("mid_rst_led", led_value, 0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_no_strobe", new_tx_data, 0);
    @(posedge clk); #1;
    tick(5);
    check("mid_rst_queue_gone", tx_log.size() - mark, 0);
    seq = '{8'h46, 8'h0A};
    send_seq(2);
    tick(6);
    check("mid_rst_tx_cnt", tx_log.size() - mark, 1);
    check("mid_rst_tx_nak", tx_at(mark), 8'h3F);
    check("mid_rst_div_kept", div_value, DIV_RST);
    check("mid_rst_led_kept", led_value, 0);

    // Randomized command streams
    mark = tx_log.size(); err_base = err_seen; upd_base = upd_seen;
    m_exp_tx.delete(); m_err = 0; m_upd = 0;
    for (int c = 0; c < 60; c++) begin
      int kind, pos;
      kind = $urandom_range(0, 9);
      seq.push_back(($urandom_range(0, 1) == 1) ? 8'h4C : 8'h44);
      seq.push_back(hex_char($urandom_range(0, 15), $urandom_range(0, 1) == 1));
      if (kind != 7) seq.push_back(hex_char($urandom_range(0, 15), $urandom_range(0, 1) == 1));
      if (kind == 9) seq.push_back(hex_char($urandom_range(0, 15), 1'b1));
      seq.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      if (kind == 6) begin
        pos = $urandom_range(0, seq.size() - 1);
        seq[pos] = 8'($urandom);
      end
      if (kind == 8) begin
        seq.delete();
        repeat ($urandom_range(1, 3)) seq.push_back(8'($urandom));
        seq.push_back(8'h0A);
      end
      send_seq($urandom_range(3, 6));
      tick(8);
      check("rnd_led", led_value, m_led);
      check("rnd_div", div_value, m_div);
      check("rnd_err", err_seen - err_base, m_err);
      check("rnd_upd", upd_seen - upd_base, m_upd);
      n_exp = m_exp_tx.size();
      check("rnd_tx_cnt", tx_log.size() - mark, n_exp);
      for (int i = 0; i < n_exp; i++) begin
        b = m_exp_tx.pop_front();
        check("rnd_tx", tx_at(mark), b);
        mark++;
      end
      mark = tx_log.size();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
